proc_imul_share_arb: RTL
========================

// Module: proc_imul_share_arb
//
// PURPOSE
//  Round-robin arbiter sharing one iterative multiplier (lab1_imul_IntMulVarLatVRTL)
//  among p_num_cores processor datapaths. It sits between each core's D-stage
//  imul request and X-stage imul response and the single shared multiplier.
//  At most one multiply is outstanding. The response is routed to the owning core only.
//
// PARAMETERS
//  p_num_cores  4  number of requesting cores (>=1); core index width c_idx_w = max(1,$clog2(p_num_cores))
//
// PORTS
//  clk            in   1          clock
//  reset          in   1          synchronous, active-high reset
//  req_val        in   N          per-core request valid (N = p_num_cores)
//  req_rdy        out  N          per-core request ready
//  req_msg        in   64*N       per-core {op1,op2}; core i at [64*i+:64]
//  resp_val       out  N          per-core response valid
//  resp_rdy       in   N          per-core response ready
//  resp_msg       out  32         product, broadcast to all cores (qualified by resp_val)
//  imul_req_val   out  1          to multiplier
//  imul_req_rdy   in   1          from multiplier
//  imul_req_msg   out  64         to multiplier
//  imul_resp_val  in   1          from multiplier
//  imul_resp_rdy  out  1          to multiplier
//  imul_resp_msg  in   32         from multiplier
//  owner          out  c_idx_w    core index of the in-flight / granted transaction
//  busy           out  1          1 while a multiply is outstanding
//
// BEHAVIOUR
//  - Fire = val && rdy in the same cycle. All handshakes are val/rdy. A requester holds val and msg until fire.
//  - State register: IDLE(0), BUSY(1). Registers: state, owner_reg, rr_ptr (c_idx_w bits).
//  - Reset: state=IDLE, owner_reg=0, rr_ptr=0. Outputs during and after reset:
//    req_rdy=0, resp_val=0, imul_req_val=0, imul_resp_rdy=0, busy=0, owner=0.
//  - IDLE:
//    grant g = first i with req_val[i]=1, searched i=rr_ptr, rr_ptr+1, ... mod N.
//    imul_req_val = |req_val.
//    imul_req_msg = req_msg[g] (0 if none valid).
//    req_rdy[g] = imul_req_rdy; all other req_rdy = 0.
//    owner = g.
//    resp_val=0, imul_resp_rdy=0.
//  - IDLE, on imul request fire:
//    owner_reg<=g; rr_ptr<=(g+1) mod N (g=N-1 wraps to 0); state<=BUSY.
//    Without a fire: rr_ptr and owner_reg hold.
//  - BUSY:
//    imul_req_val=0, all req_rdy=0.
//    resp_val[owner_reg]=imul_resp_val; all other resp_val = 0.
//    imul_resp_rdy=resp_rdy[owner_reg].
//    resp_msg=imul_resp_msg; owner=owner_reg; busy=1.
//    Requests arriving in BUSY wait; they are not dropped.
//  - BUSY, on response fire: state<=IDLE. A new request is acceptable in the next cycle.
//    Arbiter adds zero latency to the request path. Minimum gap is one cycle from response fire to the next request fire.
//  - Owner applies resp_rdy=0 (stall): the response stays pending and arbiter stays BUSY.
//    The multiplier holds its response per val/rdy.
//  - Spurious imul_resp_val while IDLE is ignored: imul_resp_rdy=0, no resp_val.
//  - Combinational paths (must not loop):
//    imul_req_rdy -> req_rdy.
//    req_val -> imul_req_val.
//    resp_rdy -> imul_resp_rdy.
//    imul_resp_val -> resp_val.
//  - Reset mid-operation: returns to IDLE with rr_ptr=0. Any in-flight result is discarded.
//    The multiplier shares the same reset.
//  - N=1: rr_ptr stays 0. Behaves as a pass-through with a one-outstanding limit.
//
// TESTING
//  1. Single core 0: request {3,5} -> imul_req_msg={32'd3,32'd5}, fire.
//     Core 0 gets resp_val[0]=1, resp_msg=15. resp_val[1..3]=0 throughout.
//  2. Cores 0-3 all request simultaneously from reset.
//     Grants go in order 0,1,2,3 with one multiply outstanding at a time. Each core receives its own product.
//  3. After core 3 is served, cores 3 and 0 request.
//     rr_ptr=0 after wrap, so core 0 is granted first, then core 3.
//  4. Owner holds resp_rdy=0 for 5 cycles.
//     busy stays 1, resp_val stays asserted with a stable resp_msg, no new grant. Request fires the cycle after resp_rdy=1.
//  5. Core 2 busy; core 1 asserts req_val.
//     req_rdy[1]=0 until core 2's response fires. Core 1 is granted the next cycle with its msg unchanged.
//  6. Assert reset while BUSY.
//     Next cycle state=IDLE, busy=0, owner=0, all resp_val=0. A subsequent request from core 1 proceeds normally.

Source files
------------

// File: rtl/proc_imul_share_arb.sv
// Round-robin arbiter that lets several processor datapaths share one iterative
// multiplier, with a single multiply outstanding and responses steered to the owner.
module proc_imul_share_arb #(
  parameter  int p_num_cores = 4,
  localparam int c_idx_w     = (p_num_cores > 1) ? $clog2(p_num_cores) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [p_num_cores-1:0]    req_val,
  output logic [p_num_cores-1:0]    req_rdy,
  input  logic [64*p_num_cores-1:0] req_msg,
  output logic [p_num_cores-1:0]    resp_val,
  input  logic [p_num_cores-1:0]    resp_rdy,
  output logic [31:0]               resp_msg,
  output logic                      imul_req_val,
  input  logic                      imul_req_rdy,
  output logic [63:0]               imul_req_msg,
  input  logic                      imul_resp_val,
  output logic                      imul_resp_rdy,
  input  logic [31:0]               imul_resp_msg,
  output logic [c_idx_w-1:0]        owner,
  output logic                      busy
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BUSY = 1'b1} state_t;

  state_t             state_r;
  logic [c_idx_w-1:0] owner_reg_r;
  logic [c_idx_w-1:0] rr_ptr_r;

  logic [c_idx_w-1:0] grant_s;
  logic               grant_val_s;
  logic [63:0]        grant_msg_s;
  logic [c_idx_w-1:0] rr_next_s;
  logic               req_fire_s;
  logic               resp_fire_s;
  int                 idx_v;

  // Round-robin search starting at rr_ptr; first valid requester wins
  always_comb begin
    grant_s     = '0;
    grant_val_s = 1'b0;
    grant_msg_s = 64'd0;
    idx_v       = 0;
    for (int k = 0; k < p_num_cores; k++) begin
      idx_v = (int'(rr_ptr_r) + k) % p_num_cores;
      if (!grant_val_s && req_val[idx_v]) begin
        grant_val_s = 1'b1;
        grant_s     = c_idx_w'(idx_v);
        grant_msg_s = req_msg[64*idx_v +: 64];
      end else begin
        grant_val_s = grant_val_s;
      end
    end
  end

  // Handshake qualifiers and next pointer (wraps after the last core)
  always_comb begin
    req_fire_s  = (state_r == ST_IDLE) && grant_val_s && imul_req_rdy;
    resp_fire_s = (state_r == ST_BUSY) && imul_resp_val && resp_rdy[owner_reg_r];
    if (grant_s == c_idx_w'(p_num_cores - 1)) begin
      rr_next_s = '0;
    end else begin
      rr_next_s = grant_s + 1'b1;
    end
  end

  // Control state, owner and round-robin pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      owner_reg_r <= '0;
      rr_ptr_r    <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (req_fire_s) begin
            owner_reg_r <= grant_s;
            rr_ptr_r    <= rr_next_s;
            state_r     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (resp_fire_s) begin
            state_r <= ST_IDLE;
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

  // Output steering; everything is forced quiet while reset is asserted
  always_comb begin
    req_rdy       = '0;
    resp_val      = '0;
    resp_msg      = 32'd0;
    imul_req_val  = 1'b0;
    imul_req_msg  = 64'd0;
    imul_resp_rdy = 1'b0;
    owner         = '0;
    busy          = 1'b0;
    if (!reset) begin
      case (state_r)
        ST_IDLE: begin
          imul_req_val = |req_val;
          imul_req_msg = grant_msg_s;
          owner        = grant_s;
          if (grant_val_s) begin
            req_rdy[grant_s] = imul_req_rdy;
          end else begin
            req_rdy = '0;
          end
        end
        ST_BUSY: begin
          resp_val[owner_reg_r] = imul_resp_val;
          imul_resp_rdy         = resp_rdy[owner_reg_r];
          resp_msg              = imul_resp_msg;
          owner                 = owner_reg_r;
          busy                  = 1'b1;
        end
        default: busy = 1'b0;
      endcase
    end else begin
      busy = 1'b0;
    end
  end

endmodule
